icache_dm_param: RTL and testbench

// - Parametrised direct-mapped, read-only instruction cache between fetch unit and the tagged memory bus.
// - Adds per-set valid bits, a bulk invalidate and a generic N-beat line fill.
// - Sizes are parameter-driven: sets, line size and bus width.
// - A miss issues one bus read, then fills the line beat-by-beat, then replays the lookup.

---
 rtl/icache_dm_param_if.sv | 41 ++++
 rtl/icache_dm_param.sv | 276 +++++++++++++++++++++++++++
 tb/tb_icache_dm_param.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_dm_param_if.sv
// Fetch-side and memory-bus-side signal bundle for icache_dm_param.
// slave  : the cache's view (drives proc_ack/proc_data_out and the bus request side).
// master : the environment's view (fetch unit plus tagged memory bus).
interface icache_dm_param_if #(
    parameter int BUS_DATA_WIDTH     = 64,
    parameter int BUS_TAG_WIDTH      = 13,
    parameter int WORD_SIZE          = 4,
    parameter int LOG_WORDS_PER_LINE = 4,
    parameter int ADDR_WIDTH         = 58
);
    // fetch side
    logic                          proc_req;
    logic [ADDR_WIDTH-1:0]         proc_line_addr;
    logic [LOG_WORDS_PER_LINE-1:0] proc_word_select;
    logic                          proc_ack;
    logic [WORD_SIZE*8-1:0]        proc_data_out;
    logic                          inv_all;
    // memory bus side
    logic                          bus_reqcyc;
    logic [BUS_DATA_WIDTH-1:0]     bus_req;
    logic [BUS_TAG_WIDTH-1:0]      bus_reqtag;
    logic                          bus_reqack;
    logic                          bus_respcyc;
    logic [BUS_DATA_WIDTH-1:0]     bus_resp;
    logic [BUS_TAG_WIDTH-1:0]      bus_resptag;
    logic                          bus_respack;

    modport slave (
        input  proc_req, proc_line_addr, proc_word_select, inv_all,
        input  bus_reqack, bus_respcyc, bus_resp, bus_resptag,
        output proc_ack, proc_data_out,
        output bus_reqcyc, bus_req, bus_reqtag, bus_respack
    );

    modport master (
        output proc_req, proc_line_addr, proc_word_select, inv_all,
        output bus_reqack, bus_respcyc, bus_resp, bus_resptag,
        input  proc_ack, proc_data_out,
        input  bus_reqcyc, bus_req, bus_reqtag, bus_respack
    );
endinterface

// File: rtl/icache_dm_param.sv
// Parametrised direct-mapped read-only instruction cache.
// A miss issues one tagged bus read, fills the line beat by beat, then replays
// the lookup (which is then a guaranteed hit). inv_all clears every valid bit,
// deferred to the next IDLE if it arrives while a request is in flight.
// Optional feature macro: ICACHE_PERF_CNT_EN adds saturating hit_count/miss_count outputs.
module icache_dm_param #(
    parameter int BUS_DATA_WIDTH     = 64,
    parameter int BUS_TAG_WIDTH      = 13,
    parameter int WORD_SIZE          = 4,
    parameter int LOG_WORDS_PER_LINE = 4,
    parameter int ADDR_WIDTH         = 58,
    parameter int LOG_NUM_SETS       = 4,
    parameter logic [BUS_TAG_WIDTH-1:0] REQ_TAG = 13'h1100
) (
    input  logic clk,
    input  logic reset,
    icache_dm_param_if.slave cif
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int WORD_BITS = WORD_SIZE * 8;
    localparam int LINE_BITS = WORD_BITS * (2 ** LOG_WORDS_PER_LINE);
    localparam int BEATS     = LINE_BITS / BUS_DATA_WIDTH;
    localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int NUM_SETS  = 2 ** LOG_NUM_SETS;
    localparam int TAG_W     = ADDR_WIDTH - LOG_NUM_SETS;
    localparam int OFF_BITS  = $clog2(WORD_SIZE) + LOG_WORDS_PER_LINE;
    localparam int BA_W      = ADDR_WIDTH + OFF_BITS;
    localparam int EXT_W     = (BA_W > BUS_DATA_WIDTH) ? BA_W : BUS_DATA_WIDTH;

    generate
        if (LINE_BITS % BUS_DATA_WIDTH != 0) begin : g_bad_line
            $error("LINE_BITS must be a multiple of BUS_DATA_WIDTH");
        end
        if (ADDR_WIDTH <= LOG_NUM_SETS) begin : g_bad_addr
            $error("ADDR_WIDTH must exceed LOG_NUM_SETS");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_REQ    = 3'd2,
        ST_FILL   = 3'd3,
        ST_FLUSH  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // storage arrays (tag/data are not reset; valid bits guard them)
    logic [NUM_SETS-1:0]  r_valid;
    logic [TAG_W-1:0]     r_tag  [NUM_SETS];
    logic [LINE_BITS-1:0] r_data [NUM_SETS];

    // request context and control
    logic [ADDR_WIDTH-1:0]         r_addr;
    logic [LOG_WORDS_PER_LINE-1:0] r_word;
    logic [BEAT_W-1:0]             r_beat;
    logic                          r_pend;
    logic                          r_replay;

    // registered outputs
    logic                      r_ack;
    logic [WORD_BITS-1:0]      r_dout;
    logic                      r_reqcyc;
    logic [BUS_DATA_WIDTH-1:0] r_req;
    logic [BUS_TAG_WIDTH-1:0]  r_reqtag;
    logic                      r_respack;

    // lookup datapath
    logic [LOG_NUM_SETS-1:0]   w_idx;
    logic [TAG_W-1:0]          w_tag;
    logic                      w_hit;
    logic [LINE_BITS-1:0]      w_line;
    logic [WORD_BITS-1:0]      w_word;
    logic                      w_beat_ok;
    logic                      w_last;
    logic [EXT_W-1:0]          w_byte_ext;
    logic [BUS_DATA_WIDTH-1:0] w_req_addr;

    // FSM-decoded strobes
    logic w_capture;
    logic w_do_ack;
    logic w_do_req;
    logic w_req_done;
    logic w_beat_wr;
    logic w_fill_done;
    logic w_flush;

    assign w_idx      = r_addr[LOG_NUM_SETS-1:0];
    assign w_tag      = r_addr[ADDR_WIDTH-1:LOG_NUM_SETS];
    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_line     = r_data[w_idx];
    assign w_word     = w_line[r_word*WORD_BITS +: WORD_BITS];
    assign w_beat_ok  = cif.bus_respcyc && (cif.bus_resptag == REQ_TAG);
    assign w_last     = (r_beat == BEAT_W'(BEATS - 1));
    assign w_byte_ext = EXT_W'({r_addr, {OFF_BITS{1'b0}}});
    assign w_req_addr = w_byte_ext[BUS_DATA_WIDTH-1:0];

    // Next-state and per-state strobes; invalidate has priority over a new fetch in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_do_ack    = 1'b0;
        w_do_req    = 1'b0;
        w_req_done  = 1'b0;
        w_beat_wr   = 1'b0;
        w_fill_done = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cif.inv_all || r_pend) begin
                    w_state_nxt = ST_FLUSH;
                end else if (cif.proc_req) begin
                    w_state_nxt = ST_LOOKUP;
                    w_capture   = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                if (w_hit) begin
                    w_state_nxt = ST_IDLE;
                    w_do_ack    = 1'b1;
                end else begin
                    w_state_nxt = ST_REQ;
                    w_do_req    = 1'b1;
                end
            end
            ST_REQ: begin
                if (cif.bus_reqack) begin
                    w_state_nxt = ST_FILL;
                    w_req_done  = 1'b1;
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_FILL: begin
                w_beat_wr = w_beat_ok;
                if (w_beat_ok && w_last) begin
                    w_state_nxt = ST_LOOKUP;
                    w_fill_done = 1'b1;
                end else begin
                    w_state_nxt = ST_FILL;
                end
            end
            ST_FLUSH: begin
                w_state_nxt = ST_IDLE;
                w_flush     = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Control registers, valid bits and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid   <= {NUM_SETS{1'b0}};
            r_addr    <= {ADDR_WIDTH{1'b0}};
            r_word    <= {LOG_WORDS_PER_LINE{1'b0}};
            r_beat    <= {BEAT_W{1'b0}};
            r_pend    <= 1'b0;
            r_replay  <= 1'b0;
            r_ack     <= 1'b0;
            r_dout    <= {WORD_BITS{1'b0}};
            r_reqcyc  <= 1'b0;
            r_req     <= {BUS_DATA_WIDTH{1'b0}};
            r_reqtag  <= {BUS_TAG_WIDTH{1'b0}};
            r_respack <= 1'b0;
        end else begin
            if (w_capture) begin
                r_addr <= cif.proc_line_addr;
                r_word <= cif.proc_word_select;
            end

            r_ack <= w_do_ack;
            if (w_do_ack) begin
                r_dout <= w_word;
            end

            if (w_do_req) begin
                r_reqcyc <= 1'b1;
                r_req    <= w_req_addr;
                r_reqtag <= REQ_TAG;
            end else if (w_req_done) begin
                r_reqcyc <= 1'b0;
                r_req    <= {BUS_DATA_WIDTH{1'b0}};
                r_reqtag <= {BUS_TAG_WIDTH{1'b0}};
            end

            if (w_req_done) begin
                r_beat <= {BEAT_W{1'b0}};
            end else if (w_beat_wr) begin
                r_beat <= r_beat + BEAT_W'(1);
            end

            r_respack <= w_beat_wr;

            // replay lookup after a fill is flagged so it is not counted as a new outcome
            if (w_fill_done) begin
                r_replay <= 1'b1;
            end else if (r_state == ST_LOOKUP) begin
                r_replay <= 1'b0;
            end

            // an invalidate seen away from IDLE is remembered until the flush runs
            if (w_flush) begin
                r_pend <= 1'b0;
            end else if (cif.inv_all && (r_state != ST_IDLE)) begin
                r_pend <= 1'b1;
            end

            if (w_flush) begin
                r_valid <= {NUM_SETS{1'b0}};
            end else if (w_fill_done) begin
                r_valid[w_idx] <= 1'b1;
            end
        end
    end

    // Line data written one beat at a time; tag written with the final beat.
    always_ff @(posedge clk) begin
        if (!reset && w_beat_wr) begin
            r_data[w_idx][r_beat*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] <= cif.bus_resp;
        end
        if (!reset && w_fill_done) begin
            r_tag[w_idx] <= w_tag;
        end
    end

    assign cif.proc_ack      = r_ack;
    assign cif.proc_data_out = r_dout;
    assign cif.bus_reqcyc    = r_reqcyc;
    assign cif.bus_req       = r_req;
    assign cif.bus_reqtag    = r_reqtag;
    assign cif.bus_respack   = r_respack;

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    // Saturating counters, one increment per first-time lookup outcome.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_count  <= 32'd0;
            r_miss_count <= 32'd0;
        end else begin
            if (w_do_ack && !r_replay && (r_hit_count != 32'hFFFF_FFFF)) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_do_req && (r_miss_count != 32'hFFFF_FFFF)) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_icache_dm_param.sv
// Self-checking bench for icache_dm_param: a set-level cache model (which line
// lives in each set, and its data) predicts hit/miss, bus addresses and data.
module tb_icache_dm_param;
    localparam int BDW   = 64;
    localparam int BTW   = 13;
    localparam int WS    = 4;
    localparam int LWPL  = 4;
    localparam int AW    = 58;
    localparam int LNS   = 4;
    localparam int BEATS = 8;
    localparam int NSETS = 16;
    localparam logic [BTW-1:0] RTAG = 13'h1100;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    icache_dm_param_if #(.BUS_DATA_WIDTH(BDW), .BUS_TAG_WIDTH(BTW), .WORD_SIZE(WS),
                         .LOG_WORDS_PER_LINE(LWPL), .ADDR_WIDTH(AW)) bif ();

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    icache_dm_param #(.BUS_DATA_WIDTH(BDW), .BUS_TAG_WIDTH(BTW), .WORD_SIZE(WS),
                      .LOG_WORDS_PER_LINE(LWPL), .ADDR_WIDTH(AW), .LOG_NUM_SETS(LNS),
                      .REQ_TAG(RTAG)) dut (
        .clk   (clk),
        .reset (reset),
        .cif   (bif)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    // model
    bit           m_valid [NSETS];
    logic [AW-1:0] m_line [NSETS];
    logic [511:0] m_data  [NSETS];
    logic [31:0]  m_last;
    int           m_hits;
    int           m_misses;
    logic [63:0]  seen_req;
    bit           chk_en = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int s = 0; s < NSETS; s++) m_valid[s] = 1'b0;
    endtask

    // Continuous checks: request tag rule and output data hold between acks.
    always @(negedge clk) begin
        if (chk_en && !reset) begin
            check("reqtag_rule", 64'(bif.bus_reqtag), bif.bus_reqcyc ? 64'(RTAG) : 64'd0);
            if (!bif.proc_ack) check("data_hold", 64'(bif.proc_data_out), 64'(m_last));
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"},     64'(bif.proc_ack), 64'd0);
        check({tag, "_dout"},    64'(bif.proc_data_out), 64'd0);
        check({tag, "_reqcyc"},  64'(bif.bus_reqcyc), 64'd0);
        check({tag, "_req"},     bif.bus_req, 64'd0);
        check({tag, "_reqtag"},  64'(bif.bus_reqtag), 64'd0);
        check({tag, "_respack"}, 64'(bif.bus_respack), 64'd0);
    endtask

    task automatic inv_idle();
        bif.inv_all = 1'b1;
        cyc();
        bif.inv_all = 1'b0;
        model_clear();
        cyc();
    endtask

    // One fetch: predicts hit/miss from the model, plays the bus side, checks results.
    task automatic read(input logic [AW-1:0] line, input int word, input bit det,
                        input bit bad, input int inv_at, input int rst_at,
                        output logic [31:0] rd);
        int idx;
        bit hit;
        bit got;
        logic [511:0] nd;
        logic [31:0] exp;
        logic [63:0] exp_req;
        idx = int'(line[LNS-1:0]);
        hit = m_valid[idx] && (m_line[idx] == line);
        exp_req = 64'(line) << 6;
        rd = 32'd0;
        bif.proc_req = 1'b1;
        bif.proc_line_addr = line;
        bif.proc_word_select = LWPL'(word);
        if (hit) begin
            m_hits++;
            exp = m_data[idx][word*32 +: 32];
            cyc();
            check("hit_ack_early", 64'(bif.proc_ack), 64'd0);
            cyc();
            check("hit_ack", 64'(bif.proc_ack), 64'd1);
            check("hit_data", 64'(bif.proc_data_out), 64'(exp));
            check("hit_no_reqcyc", 64'(bif.bus_reqcyc), 64'd0);
            bif.proc_req = 1'b0;
            m_last = exp;
            rd = bif.proc_data_out;
        end else begin
            m_misses++;
            got = 1'b0;
            for (int c = 0; c < 10; c++) begin
                cyc();
                if (bif.bus_reqcyc) begin
                    got = 1'b1;
                    break;
                end
                check("miss_no_ack", 64'(bif.proc_ack), 64'd0);
            end
            if (!got) check("reqcyc_timeout", 64'(bif.bus_reqcyc), 64'd1);
            seen_req = bif.bus_req;
            check("bus_req", bif.bus_req, exp_req);
            check("bus_reqtag", 64'(bif.bus_reqtag), 64'(RTAG));
            repeat ($urandom_range(0, 3)) begin
                cyc();
                check("req_held", 64'(bif.bus_reqcyc), 64'd1);
                check("req_addr_held", bif.bus_req, exp_req);
            end
            bif.bus_reqack = 1'b1;
            cyc();
            bif.bus_reqack = 1'b0;
            check("reqcyc_drop", 64'(bif.bus_reqcyc), 64'd0);
            for (int w = 0; w < 16; w++) nd[w*32 +: 32] = det ? (32'hA000_0000 + 32'(w)) : 32'($urandom);
            for (int b = 0; b < BEATS; b++) begin
                if (bad && ($urandom_range(0, 1) == 1)) begin
                    bif.bus_respcyc = 1'b1;
                    bif.bus_resptag = 13'h0042;
                    bif.bus_resp = {32'($urandom), 32'($urandom)};
                    cyc();
                    bif.bus_respcyc = 1'b0;
                    check("bad_no_respack", 64'(bif.bus_respack), 64'd0);
                end
                if ($urandom_range(0, 3) == 0) begin
                    cyc();
                    check("gap_no_respack", 64'(bif.bus_respack), 64'd0);
                end
                bif.bus_respcyc = 1'b1;
                bif.bus_resptag = RTAG;
                bif.bus_resp = nd[b*64 +: 64];
                if (b == inv_at) bif.inv_all = 1'b1;
                if (b == rst_at) begin
                    reset = 1'b1;
                    bif.proc_req = 1'b0;
                end
                cyc();
                bif.bus_respcyc = 1'b0;
                bif.inv_all = 1'b0;
                if (b == rst_at) begin
                    reset = 1'b0;
                    m_last = 32'd0;
                    check_all_zero("midfill_rst");
                    model_clear();
                    m_hits = 0;
                    m_misses = 0;
                    repeat (3) begin
                        bif.bus_respcyc = 1'b1;
                        bif.bus_resptag = RTAG;
                        bif.bus_resp = {32'($urandom), 32'($urandom)};
                        cyc();
                        check("late_no_respack", 64'(bif.bus_respack), 64'd0);
                        check("late_no_ack", 64'(bif.proc_ack), 64'd0);
                    end
                    bif.bus_respcyc = 1'b0;
                    cyc();
                    return;
                end
                check("beat_respack", 64'(bif.bus_respack), 64'd1);
            end
            m_valid[idx] = 1'b1;
            m_line[idx] = line;
            m_data[idx] = nd;
            exp = nd[word*32 +: 32];
            got = 1'b0;
            for (int c = 0; c < 8; c++) begin
                cyc();
                check("fill_respack_end", 64'(bif.bus_respack), 64'd0);
                if (bif.proc_ack) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) check("ack_timeout", 64'(bif.proc_ack), 64'd1);
            check("miss_data", 64'(bif.proc_data_out), 64'(exp));
            bif.proc_req = 1'b0;
            m_last = exp;
            rd = bif.proc_data_out;
            if (inv_at >= 0) model_clear();
        end
        cyc();
        check("ack_pulse", 64'(bif.proc_ack), 64'd0);
    endtask

    logic [31:0] rd;

    initial begin
        bif.proc_req = 1'b0;
        bif.proc_line_addr = '0;
        bif.proc_word_select = '0;
        bif.inv_all = 1'b0;
        bif.bus_reqack = 1'b0;
        bif.bus_respcyc = 1'b0;
        bif.bus_resp = '0;
        bif.bus_resptag = '0;
        m_last = 32'd0;
        m_hits = 0;
        m_misses = 0;
        seen_req = 64'd0;
        model_clear();

        reset = 1'b1;
        repeat (3) cyc();
        reset = 1'b0;
        check_all_zero("reset");
        chk_en = 1'b1;
        cyc();

        // first miss with known data, then a hit in the same line
        read(58'h10, 3, 1'b1, 1'b0, -1, -1, rd);
        check("pin_bus_req_0x10", seen_req, 64'h400);
        check("pin_word3", 64'(rd), 64'hA000_0003);
        read(58'h10, 15, 1'b0, 1'b0, -1, -1, rd);
        check("pin_word15_hit", 64'(rd), 64'hA000_000F);

        // conflicting lines in set 0
        read(58'h20, 0, 1'b0, 1'b0, -1, -1, rd);
        read(58'h10, 5, 1'b0, 1'b0, -1, -1, rd);

        // foreign-tagged beats interleaved
        read(58'h31, 2, 1'b0, 1'b1, -1, -1, rd);
        read(58'h31, 9, 1'b0, 1'b0, -1, -1, rd);

        // invalidate while idle
        inv_idle();
        read(58'h10, 1, 1'b0, 1'b0, -1, -1, rd);

        // invalidate during a fill: the fill still acks, then 0x10 misses again
        read(58'h20, 4, 1'b0, 1'b0, -1, -1, rd);
        read(58'h10, 7, 1'b0, 1'b0, 3, -1, rd);
        read(58'h10, 8, 1'b0, 1'b0, -1, -1, rd);

        // reset mid-fill, then a refill of the same line
        inv_idle();
        read(58'h10, 6, 1'b0, 1'b0, -1, 4, rd);
        read(58'h10, 6, 1'b0, 1'b0, -1, -1, rd);
        read(58'h10, 12, 1'b0, 1'b0, -1, -1, rd);

        // randomized traffic
        for (int t = 0; t < 60; t++) begin
            logic [AW-1:0] ln;
            if ($urandom_range(0, 7) == 0) ln = AW'({32'($urandom), 32'($urandom)});
            else ln = AW'($urandom_range(0, 63));
            if ($urandom_range(0, 15) == 0) inv_idle();
            read(ln, int'($urandom_range(0, 15)), 1'b0, bit'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1, -1, rd);
        end

`ifdef ICACHE_PERF_CNT_EN
        check("hit_count", 64'(hit_count), 64'(m_hits));
        check("miss_count", 64'(miss_count), 64'(m_misses));
`endif

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
